// File: rtl/modulo_pilha_retorno.sv
`default_nettype none
// ============================================================================
// Module   : modulo_pilha_retorno
// Purpose  : Program counter and return-address stack. It sits between
//            instruction decode and the instruction memory address port.
//            Jump-and-link pushes PC+1 and jumps; return pops the saved
//            address back into the PC. Overflow and underflow set a sticky
//            error flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_WIDTH       width of PC, jump targets and stack entries
//   DEPTH            number of return-address entries (power of two, >= 2)
// Ports
//   i_clock          system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_habilita       advance enable; 0 freezes PC, level, stack and error
//   i_salto          plain jump to i_endereco_salto
//   i_salto_link     push PC+1 and jump to i_endereco_salto
//   i_retorno        pop top of stack into the PC
//   i_endereco_salto jump target from decode
//   i_limpa_erro     clears o_erro_pilha (honoured even when disabled)
//   o_pc             current instruction address (registered)
//   o_topo           top-of-stack value, 0 when empty (combinational)
//   o_nivel          number of valid entries, 0..DEPTH (registered)
//   o_vazia          stack empty (registered)
//   o_cheia          stack full (registered)
//   o_erro_pilha     sticky overflow/underflow flag (registered)
// ============================================================================
module modulo_pilha_retorno #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_habilita,
  input  logic                       i_salto,
  input  logic                       i_salto_link,
  input  logic                       i_retorno,
  input  logic [ADDR_WIDTH-1:0]      i_endereco_salto,
  input  logic                       i_limpa_erro,
  output logic [ADDR_WIDTH-1:0]      o_pc,
  output logic [ADDR_WIDTH-1:0]      o_topo,
  output logic [$clog2(DEPTH):0]     o_nivel,
  output logic                       o_vazia,
  output logic                       o_cheia,
  output logic                       o_erro_pilha
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [c_LVL_W-1:0]    c_LVL_ZERO = '0;
  localparam logic [c_LVL_W-1:0]    c_LVL_ONE  = c_LVL_W'(1);
  localparam logic [c_LVL_W-1:0]    c_LVL_FULL = c_LVL_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_PC_ONE   = ADDR_WIDTH'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [c_LVL_W-1:0]    r_nivel;
  logic                  r_vazia;
  logic                  r_cheia;
  logic                  r_erro;
  logic [ADDR_WIDTH-1:0] r_stack [DEPTH];

  // --------------------------------------------------------------------------
  // Command decode (retorno > salto_link > salto > increment)
  // --------------------------------------------------------------------------
  logic w_do_ret;
  logic w_do_link;
  logic w_do_jump;
  logic w_push;
  logic w_pop;
  logic w_overflow;
  logic w_underflow;

  always_comb begin
    w_do_ret    = i_habilita & i_retorno;
    w_do_link   = i_habilita & ~i_retorno & i_salto_link;
    w_do_jump   = i_habilita & ~i_retorno & ~i_salto_link & i_salto;
    w_push      = w_do_link & ~r_cheia;
    w_pop       = w_do_ret  & ~r_vazia;
    w_overflow  = w_do_link &  r_cheia;
    w_underflow = w_do_ret  &  r_vazia;
  end

  // --------------------------------------------------------------------------
  // Stack addressing. The top entry lives at nivel-1; a push writes nivel,
  // which is always below DEPTH when a push is allowed, so dropping the MSB
  // of the level is safe for both indices.
  // --------------------------------------------------------------------------
  logic [c_LVL_W-1:0]    w_nivel_dec;
  logic [c_PTR_W-1:0]    w_top_idx;
  logic [c_PTR_W-1:0]    w_push_idx;
  logic [ADDR_WIDTH-1:0] w_topo;
  logic [ADDR_WIDTH-1:0] w_pc_inc;

  always_comb begin
    w_nivel_dec = r_nivel - c_LVL_ONE;
    w_top_idx   = w_nivel_dec[c_PTR_W-1:0];
    w_push_idx  = r_nivel[c_PTR_W-1:0];
    w_topo      = r_vazia ? '0 : r_stack[w_top_idx];
    // Carry discarded: the last address wraps to 0, and a link there pushes 0.
    w_pc_inc    = r_pc + c_PC_ONE;
  end

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [c_LVL_W-1:0]    w_nivel_nxt;
  logic                  w_erro_nxt;

  always_comb begin
    w_pc_nxt    = r_pc;
    w_nivel_nxt = r_nivel;
    w_erro_nxt  = r_erro;

    if (i_habilita) begin
      if (w_pop) begin
        w_pc_nxt = w_topo;
      end else if (w_do_link || w_do_jump) begin
        // Overflowing links still take the jump; only the push is dropped.
        w_pc_nxt = i_endereco_salto;
      end else begin
        // Plain increment, and also the recovery path for an underflow.
        w_pc_nxt = w_pc_inc;
      end
    end

    if (w_push) begin
      w_nivel_nxt = r_nivel + c_LVL_ONE;
    end else if (w_pop) begin
      w_nivel_nxt = w_nivel_dec;
    end

    // Setting has priority over clearing when both happen together.
    if (w_overflow || w_underflow) begin
      w_erro_nxt = 1'b1;
    end else if (i_limpa_erro) begin
      w_erro_nxt = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc    <= '0;
      r_nivel <= '0;
      r_vazia <= 1'b1;
      r_cheia <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_nivel <= w_nivel_nxt;
      // Flags are registered from the next level so they line up with r_nivel.
      r_vazia <= (w_nivel_nxt == c_LVL_ZERO);
      r_cheia <= (w_nivel_nxt == c_LVL_FULL);
      r_erro  <= w_erro_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Stack storage. No reset: entries above nivel are never observed.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_pc         = r_pc;
  assign o_topo       = w_topo;
  assign o_nivel      = r_nivel;
  assign o_vazia      = r_vazia;
  assign o_cheia      = r_cheia;
  assign o_erro_pilha = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_modulo_pilha_retorno.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_pilha_retorno
// Purpose  : Directed self-checking bench for modulo_pilha_retorno.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_modulo_pilha_retorno;

  localparam int c_AW    = 13;
  localparam int c_DEPTH = 8;
  localparam int c_LW    = $clog2(c_DEPTH) + 1;

  logic              r_clock;
  logic              r_reset_n;
  logic              r_habilita;
  logic              r_salto;
  logic              r_salto_link;
  logic              r_retorno;
  logic [c_AW-1:0]   r_endereco;
  logic              r_limpa;
  logic [c_AW-1:0]   w_pc;
  logic [c_AW-1:0]   w_topo;
  logic [c_LW-1:0]   w_nivel;
  logic              w_vazia;
  logic              w_cheia;
  logic              w_erro;

  int n_checks = 0;
  int n_passed = 0;

  modulo_pilha_retorno #(
    .ADDR_WIDTH (c_AW),
    .DEPTH      (c_DEPTH)
  ) u_dut (
    .i_clock          (r_clock),
    .i_reset_n        (r_reset_n),
    .i_habilita       (r_habilita),
    .i_salto          (r_salto),
    .i_salto_link     (r_salto_link),
    .i_retorno        (r_retorno),
    .i_endereco_salto (r_endereco),
    .i_limpa_erro     (r_limpa),
    .o_pc             (w_pc),
    .o_topo           (w_topo),
    .o_nivel          (w_nivel),
    .o_vazia          (w_vazia),
    .o_cheia          (w_cheia),
    .o_erro_pilha     (w_erro)
  );

  initial r_clock = 1'b0;
  always #5 r_clock = ~r_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic hab, input logic ret, input logic lnk,
                     input logic sal, input logic [c_AW-1:0] addr, input logic clr);
    r_habilita   = hab;
    r_retorno    = ret;
    r_salto_link = lnk;
    r_salto      = sal;
    r_endereco   = addr;
    r_limpa      = clr;
  endtask

  // Apply the current command at the next rising edge, then sample 1ns later.
  task automatic step();
    @(posedge r_clock);
    #1;
  endtask

  initial begin
    r_reset_n = 1'b0;
    cmd(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    #12;
    chk("rst_pc",    32'(w_pc),    32'h0);
    chk("rst_nivel", 32'(w_nivel), 32'h0);
    chk("rst_vazia", 32'(w_vazia), 32'h1);
    chk("rst_cheia", 32'(w_cheia), 32'h0);
    chk("rst_topo",  32'(w_topo),  32'h0);
    chk("rst_erro",  32'(w_erro),  32'h0);
    @(negedge r_clock);
    r_reset_n = 1'b1;

    // Free-running increment
    cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("inc_pc", 32'(w_pc), 32'(i));
    end
    chk("inc_vazia", 32'(w_vazia), 32'h1);
    chk("inc_topo",  32'(w_topo),  32'h0);

    // Single link / return
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 13'h010, 1'b0);
    step();
    chk("jmp_pc", 32'(w_pc), 32'h010);
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 13'h100, 1'b0);
    step();
    chk("lnk_pc",    32'(w_pc),    32'h100);
    chk("lnk_nivel", 32'(w_nivel), 32'h1);
    chk("lnk_topo",  32'(w_topo),  32'h011);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("lnk_inc_pc", 32'(w_pc),   32'(32'h100 + i));
      chk("lnk_topo_h", 32'(w_topo), 32'h011);
    end
    cmd(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("ret_pc",    32'(w_pc),    32'h011);
    chk("ret_nivel", 32'(w_nivel), 32'h0);
    chk("ret_vazia", 32'(w_vazia), 32'h1);
    chk("ret_topo",  32'(w_topo),  32'h0);

    // Fill the stack, overflow, then unwind in LIFO order
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 13'h020, 1'b0);
    step();
    for (int i = 0; i < c_DEPTH; i++) begin
      cmd(1'b1, 1'b0, 1'b1, 1'b0, c_AW'(13'h021 + i), 1'b0);
      step();
      chk("nest_nivel", 32'(w_nivel), 32'(i + 1));
    end
    chk("full_cheia", 32'(w_cheia), 32'h1);
    chk("full_topo",  32'(w_topo),  32'h028);
    chk("full_erro",  32'(w_erro),  32'h0);
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 13'h200, 1'b0);
    step();
    chk("ovf_pc",    32'(w_pc),    32'h200);
    chk("ovf_nivel", 32'(w_nivel), 32'(c_DEPTH));
    chk("ovf_cheia", 32'(w_cheia), 32'h1);
    chk("ovf_erro",  32'(w_erro),  32'h1);
    chk("ovf_topo",  32'(w_topo),  32'h028);
    cmd(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < c_DEPTH; i++) begin
      step();
      chk("pop_pc", 32'(w_pc), 32'(32'h028 - i));
    end
    chk("pop_vazia", 32'(w_vazia), 32'h1);
    chk("pop_cheia", 32'(w_cheia), 32'h0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    chk("clr_erro", 32'(w_erro), 32'h0);

    // Underflow and error clear
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 13'h050, 1'b0);
    step();
    cmd(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("unf_pc",    32'(w_pc),    32'h051);
    chk("unf_erro",  32'(w_erro),  32'h1);
    chk("unf_nivel", 32'(w_nivel), 32'h0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step();
    chk("unf_clr", 32'(w_erro), 32'h0);
    chk("unf_clr_pc", 32'(w_pc), 32'h052);

    // Wrap: link at last address pushes 0; retorno beats salto
    cmd(1'b1, 1'b0, 1'b0, 1'b1, 13'h1FFF, 1'b0);
    step();
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 13'h000, 1'b0);
    step();
    chk("wrap_nivel", 32'(w_nivel), 32'h1);
    chk("wrap_topo",  32'(w_topo),  32'h0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("wrap_inc", 32'(w_pc), 32'h1);
    cmd(1'b1, 1'b1, 1'b0, 1'b1, 13'h0AA, 1'b0);
    step();
    chk("prio_pc",    32'(w_pc),    32'h0);
    chk("prio_nivel", 32'(w_nivel), 32'h0);

    // Freeze, with error clear still honoured
    cmd(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step();
    chk("frz_pre_erro", 32'(w_erro), 32'h1);
    chk("frz_pre_pc",   32'(w_pc),   32'h1);
    cmd(1'b0, 1'b0, 1'b1, 1'b1, 13'h333, 1'b1);
    step();
    chk("frz_pc",    32'(w_pc),    32'h1);
    chk("frz_nivel", 32'(w_nivel), 32'h0);
    chk("frz_erro",  32'(w_erro),  32'h0);

    // Three pushes, then an asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      cmd(1'b1, 1'b0, 1'b1, 1'b0, c_AW'(13'h300 + i), 1'b0);
      step();
    end
    chk("pre_rst_nivel", 32'(w_nivel), 32'h3);
    chk("pre_rst_pc",    32'(w_pc),    32'h302);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    r_reset_n = 1'b0;
    #1;
    chk("arst_pc",    32'(w_pc),    32'h0);
    chk("arst_nivel", 32'(w_nivel), 32'h0);
    chk("arst_vazia", 32'(w_vazia), 32'h1);
    chk("arst_topo",  32'(w_topo),  32'h0);
    #2;
    r_reset_n = 1'b1;
    step();
    chk("post_rst_pc", 32'(w_pc), 32'h1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
